// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI slave, the memory stage behind it
// and the verification environment.
//   - FRAME_W_DEF / DATA_W_DEF : default frame and read-data widths
//   - WR_ADDR..RD_DATA         : command codes carried in rx_data[9:8]
//   - state_t                  : SPI slave controller states
package spi_pkg;

    localparam int FRAME_W_DEF = 10;
    localparam int DATA_W_DEF  = 8;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

endpackage

// File: rtl/spi_slave.sv
// spi_slave: SPI slave front end for a command/address/data memory.
// clk doubles as the SPI bit clock: one MOSI bit is sampled and one MISO bit
// is presented per rising edge while SS_n is low.
// Ports:
//   clk       in   system / SPI bit clock
//   rst_n     in   asynchronous active-low reset
//   SS_n      in   active-low slave select, frames a transaction
//   MOSI      in   serial data in, MSB first
//   MISO      out  serial read data out, MSB first, 0 when idle
//   rx_data   out  assembled FRAME_W-bit word for the memory stage
//   rx_valid  out  one-cycle strobe marking a freshly completed rx_data
//   tx_data   in   read data returned by the memory stage
//   tx_valid  in   tx_data valid strobe
module spi_slave
    import spi_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    localparam int TXC_W = $clog2(DATA_W);

    state_t             state;
    state_t             next_state;
    logic [3:0]         bit_cnt;
    logic [FRAME_W-1:0] rx_shift;
    logic               frame_done;
    logic               rd_addr_flag;
    logic [DATA_W-1:0]  tx_shift;
    logic [TXC_W-1:0]   tx_cnt;
    logic               tx_busy;
    logic               tx_done;

    logic               shift_en;
    logic               last_bit;
    logic               tx_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The op bit sampled in CHK_CMD picks write vs. read; a second read frame
    // (address already latched) goes straight to READ_DATA.
    always_comb begin
        next_state = state;
        if (SS_n) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = CHK_CMD;
                CHK_CMD: begin
                    if (!MOSI)             next_state = WRITE;
                    else if (rd_addr_flag) next_state = READ_DATA;
                    else                   next_state = READ_ADD;
                end
                default: next_state = state;
            endcase
        end
    end

    // Once a frame has completed the shifter freezes until SS_n rises, so
    // trailing clocks under the same select never start another word.
    always_comb begin
        shift_en = !SS_n && !frame_done &&
                   (state == WRITE || state == READ_ADD || state == READ_DATA);
        last_bit = shift_en && (bit_cnt == 4'(FRAME_W - 1));
        tx_load  = !SS_n && tx_valid && (state == READ_DATA) &&
                   frame_done && !tx_busy && !tx_done;
    end

    // Datapath. MISO is registered: the capture edge already drives the
    // MSB, and the remaining bits follow one per edge. rd_addr_flag and
    // rx_data survive an SS_n abort so an interrupted read can be retried.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_done   <= 1'b0;
            rd_addr_flag <= 1'b0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            MISO         <= 1'b0;
        end else if (SS_n) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            tx_shift   <= '0;
            tx_cnt     <= '0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            MISO       <= 1'b0;
        end else begin
            rx_valid <= last_bit;
            if (shift_en) begin
                rx_shift <= {rx_shift[FRAME_W-2:0], MOSI};
                bit_cnt  <= bit_cnt + 4'd1;
            end
            if (last_bit) begin
                rx_data    <= {rx_shift[FRAME_W-2:0], MOSI};
                frame_done <= 1'b1;
                if (state == READ_ADD) begin
                    rd_addr_flag <= 1'b1;
                end
            end
            if (tx_load) begin
                MISO     <= tx_data[DATA_W-1];
                tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
                tx_cnt   <= TXC_W'(DATA_W - 1);
                tx_busy  <= 1'b1;
            end else if (tx_busy) begin
                if (tx_cnt != '0) begin
                    MISO     <= tx_shift[DATA_W-1];
                    tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                    tx_cnt   <= tx_cnt - TXC_W'(1);
                end else begin
                    MISO         <= 1'b0;
                    tx_busy      <= 1'b0;
                    tx_done      <= 1'b1;
                    rd_addr_flag <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: self-checking bench for spi_slave. Table-driven frames for
// the write/read-address paths, plus hand-written sequences for read-data
// shifting, abort, reset mid-shift and stray tx_valid.
module tb_spi_slave;
    import spi_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int total;
    int bad;
    int tick_idx;
    int valid_cnt;
    int valid_at;
    logic miso_seen;

    typedef struct {
        logic       op;
        logic [9:0] payload;
        logic [9:0] exp_data;
        logic       exp_flag;
    } vec_t;

    vec_t vecs[5];

    spi_slave #(.FRAME_W(10), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (ss_n),
        .MOSI     (mosi),
        .MISO     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle and record what the DUT shows.
    task automatic tick();
        @(posedge clk);
        #1;
        tick_idx++;
        if (rx_valid) begin
            valid_cnt++;
            valid_at = tick_idx;
        end
        miso_seen = miso_seen | miso;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Select, send op bit, then nbits of payload MSB first; SS_n stays low.
    task automatic shiftIn(input logic op, input logic [9:0] payload, input int nbits);
        tick_idx  = -1;
        valid_cnt = 0;
        valid_at  = -1;
        miso_seen = 1'b0;
        ss_n = 1'b0;
        tick();
        mosi = op;
        tick();
        for (int i = 0; i < nbits; i++) begin
            mosi = payload[9-i];
            tick();
        end
    endtask

    // Full frame, two trailing held cycles, then deselect.
    task automatic applyStimulus(input logic op, input logic [9:0] payload);
        shiftIn(op, payload, 10);
        mosi = 1'b1;
        tick();
        tick();
        ss_n = 1'b1;
        mosi = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] bits;

        total    = 0;
        bad      = 0;
        tick_idx = 0;
        rst_n    = 1'b0;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;

        vecs[0] = '{op: 1'b0, payload: 10'h0A5, exp_data: 10'h0A5, exp_flag: 1'b0};
        vecs[1] = '{op: 1'b0, payload: 10'h13C, exp_data: 10'h13C, exp_flag: 1'b0};
        vecs[2] = '{op: 1'b0, payload: 10'h2FF, exp_data: 10'h2FF, exp_flag: 1'b0};
        vecs[3] = '{op: 1'b1, payload: 10'h207, exp_data: 10'h207, exp_flag: 1'b1};
        vecs[4] = '{op: 1'b0, payload: 10'h155, exp_data: 10'h155, exp_flag: 1'b1};

        tick();
        tick();
        checkOutput("reset_miso", 32'(miso), 32'h0);
        checkOutput("reset_rx_valid", 32'(rx_valid), 32'h0);
        checkOutput("reset_rx_data", 32'(rx_data), 32'h0);
        checkOutput("reset_state", 32'(dut.state), 32'(IDLE));
        checkOutput("reset_flag", 32'(dut.rd_addr_flag), 32'h0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].op, vecs[v].payload);
            checkOutput($sformatf("vec%0d_valid_cnt", v), 32'(valid_cnt), 32'd1);
            checkOutput($sformatf("vec%0d_valid_at", v), 32'(valid_at), 32'd11);
            checkOutput($sformatf("vec%0d_rx_data", v), 32'(rx_data), 32'(vecs[v].exp_data));
            checkOutput($sformatf("vec%0d_flag", v), 32'(dut.rd_addr_flag), 32'(vecs[v].exp_flag));
            checkOutput($sformatf("vec%0d_miso", v), 32'(miso_seen), 32'h0);
            checkOutput($sformatf("vec%0d_idle", v), 32'(dut.state), 32'(IDLE));
        end

        // Read data frame: address already latched, so READ_DATA is used.
        shiftIn(1'b1, 10'h300, 10);
        checkOutput("rd_valid", 32'(rx_valid), 32'h1);
        checkOutput("rd_rx_data", 32'(rx_data), 32'h300);
        checkOutput("rd_state", 32'(dut.state), 32'(READ_DATA));
        tick();
        tick();
        checkOutput("rd_wait_miso", 32'(miso_seen), 32'h0);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        bits[7]  = miso;
        for (int i = 6; i >= 0; i--) begin
            tick();
            bits[i] = miso;
        end
        checkOutput("rd_miso_bits", 32'(bits), 32'hC3);
        tick();
        checkOutput("rd_miso_after", 32'(miso), 32'h0);
        checkOutput("rd_flag_cleared", 32'(dut.rd_addr_flag), 32'h0);
        checkOutput("rd_valid_cnt", 32'(valid_cnt), 32'd1);
        ss_n = 1'b1;
        tick();

        // Abort after 5 payload bits.
        shiftIn(1'b0, 10'h3FF, 5);
        ss_n = 1'b1;
        tick();
        checkOutput("abort_state", 32'(dut.state), 32'(IDLE));
        tick();
        tick();
        checkOutput("abort_valid_cnt", 32'(valid_cnt), 32'd0);
        checkOutput("abort_rx_data_held", 32'(rx_data), 32'h300);
        applyStimulus(1'b0, 10'h0C3);
        checkOutput("post_abort_valid_cnt", 32'(valid_cnt), 32'd1);
        checkOutput("post_abort_rx_data", 32'(rx_data), 32'h0C3);

        // Reset while MISO is mid-shift after 3 bits of 8'hE0.
        applyStimulus(1'b1, 10'h2AA);
        checkOutput("rst_pre_flag", 32'(dut.rd_addr_flag), 32'h1);
        shiftIn(1'b1, 10'h3AA, 10);
        tx_data  = 8'hE0;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        tick();
        checkOutput("rst_pre_miso", 32'(miso), 32'h1);
        ss_n  = 1'b1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_miso", 32'(miso), 32'h0);
        checkOutput("rst_mid_state", 32'(dut.state), 32'(IDLE));
        checkOutput("rst_mid_flag", 32'(dut.rd_addr_flag), 32'h0);
        checkOutput("rst_mid_rx_data", 32'(rx_data), 32'h0);
        tick();
        rst_n     = 1'b1;
        valid_cnt = 0;
        miso_seen = 1'b0;

        // Stray tx_valid while idle.
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        tick();
        tick();
        tx_valid = 1'b0;
        tick();
        checkOutput("stray_miso", 32'(miso_seen), 32'h0);
        checkOutput("stray_state", 32'(dut.state), 32'(IDLE));
        checkOutput("stray_valid_cnt", 32'(valid_cnt), 32'd0);

        // First frame after reset decodes normally.
        applyStimulus(1'b0, 10'h1A5);
        checkOutput("after_rst_valid_cnt", 32'(valid_cnt), 32'd1);
        checkOutput("after_rst_rx_data", 32'(rx_data), 32'h1A5);
        checkOutput("after_rst_flag", 32'(dut.rd_addr_flag), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
